// File: rtl/ontest_pkg.sv
// Shared types and constants for the on-board FPU test sequencer.
// Special operands are built from EXP_W and the caller's fraction width.
package ontest_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int unsigned EXP_W        = 8;
  localparam logic [31:0] LFSR_MASK    = 32'h80200003;
  localparam int unsigned NUM_SPECIALS = 5;

  // Order: +0, -inf, qNaN, min denormal, +max finite
  function automatic logic [63:0] special_operand(input logic [2:0] idx, input int unsigned fra_w);
    logic [63:0] one;
    logic [63:0] exp_ones;
    one      = 64'd1;
    exp_ones = ((one << EXP_W) - one) << fra_w;
    case (idx)
      3'd1:    special_operand = (one << (fra_w + EXP_W)) | exp_ones;
      3'd2:    special_operand = exp_ones | (one << (fra_w - 1));
      3'd3:    special_operand = one;
      3'd4:    special_operand = (exp_ones ^ (one << fra_w)) | ((one << fra_w) - one);
      default: special_operand = '0;
    endcase
  endfunction

endpackage

// File: rtl/ontest_lfsr.sv
// Galois right-shift LFSR operand generator; reloads SEED on load, advances on step.
module ontest_lfsr
  import ontest_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = 32'h3F800000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] MASK = WIDTH'(LFSR_MASK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (step) begin
      q <= (q >> 1) ^ (q[0] ? MASK : '0);
    end
  end

endmodule

// File: rtl/ontest_fpu_stim.sv
// On-board FPU test sequencer: issues LFSR operand pairs, checks result timing, folds results into a MISR.
// Optional feature macro: ONTEST_SPECIAL_EN (every 16th issue carries an IEEE special operand on op2).
module ontest_fpu_stim
  import ontest_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      NUM_VEC = 1024,
  parameter int unsigned      LATENCY = 1,
  parameter logic [WIDTH-1:0] SEED1   = 32'h3F800000,
  parameter logic [WIDTH-1:0] SEED2   = 32'h40000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic             op_valid,
  input  logic [WIDTH-1:0] result,
  input  logic             result_valid,
  (* mark_debug = "true" *) output logic [WIDTH-1:0] signature,
  (* mark_debug = "true" *) output logic [31:0]      vec_count,
  output logic             busy,
  output logic             done,
  (* mark_debug = "true" *) output logic             error
);

  localparam int unsigned      FRA_W = WIDTH - 1 - EXP_W;
  localparam logic [WIDTH-1:0] MASK  = WIDTH'(LFSR_MASK);

  state_t             r_state;
  logic [31:0]        r_issue;
  logic [LATENCY-1:0] r_pipe;
  logic [LATENCY-1:0] w_pipe_next;
  logic [WIDTH-1:0]   w_lfsr2;
  logic [WIDTH-1:0]   w_sig_next;
  logic               w_load;
  logic               w_exp_v;
  logic               w_accept;
  logic               w_mismatch;

  assign w_load      = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_pipe_next = LATENCY'({r_pipe, op_valid});
  assign w_exp_v     = r_pipe[LATENCY-1];
  assign w_accept    = result_valid & w_exp_v;
  assign w_mismatch  = result_valid ^ w_exp_v;
  assign w_sig_next  = {signature[WIDTH-2:0], ^(signature & MASK)} ^ result;

  ontest_lfsr #(.WIDTH(WIDTH), .SEED(SEED1)) u_lfsr1 (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .step  (op_valid),
    .q     (op1)
  );

  ontest_lfsr #(.WIDTH(WIDTH), .SEED(SEED2)) u_lfsr2 (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .step  (op_valid),
    .q     (w_lfsr2)
  );

`ifdef ONTEST_SPECIAL_EN
  logic [2:0] r_spec_idx;
  logic       w_special;

  assign w_special = op_valid & (r_issue[3:0] == 4'hF);
  assign op2       = w_special ? WIDTH'(special_operand(r_spec_idx, FRA_W)) : w_lfsr2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_spec_idx <= '0;
    end else if (w_load) begin
      r_spec_idx <= '0;
    end else if (w_special) begin
      r_spec_idx <= (r_spec_idx == 3'(NUM_SPECIALS - 1)) ? '0 : r_spec_idx + 3'd1;
    end
  end
`else
  assign op2 = w_lfsr2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_issue   <= '0;
      r_pipe    <= '0;
      op_valid  <= 1'b0;
      signature <= '0;
      vec_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      r_pipe <= w_pipe_next;
      if (w_load) begin
        r_state   <= RUN;
        r_issue   <= '0;
        op_valid  <= 1'b1;
        signature <= '0;
        vec_count <= '0;
        busy      <= 1'b1;
        done      <= 1'b0;
        error     <= 1'b0;
      end else begin
        if (w_accept) begin
          signature <= w_sig_next;
          vec_count <= vec_count + 32'd1;
        end
        if (w_mismatch) error <= 1'b1;
        case (r_state)
          RUN: begin
            if (r_issue == 32'(NUM_VEC - 1)) begin
              r_state  <= DRAIN;
              op_valid <= 1'b0;
            end else begin
              r_issue <= r_issue + 32'd1;
            end
          end
          // Finish on the edge that retires the last expected result so done lands one cycle after it
          DRAIN: begin
            if (w_pipe_next == '0) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ontest_fpu_stim.sv
// Directed bench for ontest_fpu_stim: three configurations with mock pipelined FPUs.
module tb_ontest_fpu_stim;

  localparam logic [31:0] SEED1 = 32'h3F800000;
  localparam logic [31:0] SEED2 = 32'h40000000;
  localparam logic [31:0] MASK  = 32'h80200003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? MASK : 32'h0);
  endfunction

  function automatic logic [31:0] lfsr_n(input logic [31:0] s, input int n);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = lfsr_step(v);
    return v;
  endfunction

  // Golden signature for n clean results from a DUT computing op1^op2
  function automatic logic [31:0] sig_model(input int n);
    logic [31:0] s1, s2, sig;
    s1 = SEED1; s2 = SEED2; sig = 32'h0;
    for (int i = 0; i < n; i++) begin
      sig = {sig[30:0], ^(sig & MASK)} ^ (s1 ^ s2);
      s1 = lfsr_step(s1);
      s2 = lfsr_step(s2);
    end
    return sig;
  endfunction

  // ---------------- DUT A: NUM_VEC=4, LATENCY=1 ----------------
  logic        rst_a, start_a, ov_a, rv_a, busy_a, done_a, err_a;
  logic [31:0] o1_a, o2_a, res_a, sig_a, cnt_a;

  ontest_fpu_stim #(.WIDTH(32), .NUM_VEC(4), .LATENCY(1)) u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .op1(o1_a), .op2(o2_a), .op_valid(ov_a),
    .result(res_a), .result_valid(rv_a), .signature(sig_a), .vec_count(cnt_a),
    .busy(busy_a), .done(done_a), .error(err_a)
  );

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      rv_a  <= 1'b0;
      res_a <= '0;
    end else begin
      rv_a  <= ov_a;
      res_a <= o1_a ^ o2_a;
    end
  end

  // ---------------- DUT B: NUM_VEC=8, LATENCY=3 ----------------
  logic        rst_b, start_b, ov_b, rv_b, busy_b, done_b, err_b, drop_b, extra_b;
  logic [31:0] o1_b, o2_b, res_b, sig_b, cnt_b;
  logic [2:0]  pv_b;
  logic [31:0] pd_b [3];
  int          rcnt_b;

  ontest_fpu_stim #(.WIDTH(32), .NUM_VEC(8), .LATENCY(3)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .op1(o1_b), .op2(o2_b), .op_valid(ov_b),
    .result(res_b), .result_valid(rv_b), .signature(sig_b), .vec_count(cnt_b),
    .busy(busy_b), .done(done_b), .error(err_b)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pv_b   <= '0;
      pd_b   <= '{default: '0};
      rcnt_b <= 0;
    end else begin
      pv_b    <= {pv_b[1:0], ov_b};
      pd_b[0] <= o1_b ^ o2_b;
      pd_b[1] <= pd_b[0];
      pd_b[2] <= pd_b[1];
      if (start_b) rcnt_b <= 0;
      else if (pv_b[2]) rcnt_b <= rcnt_b + 1;
    end
  end

  assign rv_b  = (pv_b[2] & ~(drop_b & (rcnt_b == 1))) | extra_b;
  assign res_b = pd_b[2];

  // ---------------- DUT C: NUM_VEC=32, LATENCY=1 ----------------
  logic        rst_c, start_c, ov_c, rv_c, busy_c, done_c, err_c;
  logic [31:0] o1_c, o2_c, res_c, sig_c, cnt_c;

  ontest_fpu_stim #(.WIDTH(32), .NUM_VEC(32), .LATENCY(1)) u_dut_c (
    .clk(clk), .reset(rst_c), .start(start_c), .op1(o1_c), .op2(o2_c), .op_valid(ov_c),
    .result(res_c), .result_valid(rv_c), .signature(sig_c), .vec_count(cnt_c),
    .busy(busy_c), .done(done_c), .error(err_c)
  );

  always_ff @(posedge clk or negedge rst_c) begin
    if (!rst_c) begin
      rv_c  <= 1'b0;
      res_c <= '0;
    end else begin
      rv_c  <= ov_c;
      res_c <= o1_c ^ o2_c;
    end
  end

  logic [31:0] b_first_op1, b_first_op2;
  logic        b_first_ov;

  // Start B, optionally pulse start again at cycles p1/p2, return the cycle done rose
  task automatic run_b(input int p1, input int p2, output int cyc);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1;
    b_first_op1 = o1_b;
    b_first_op2 = o2_b;
    b_first_ov  = ov_b;
    while (!done_b && cyc < 200) begin
      if (cyc == p1 || cyc == p2) start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int iss;
    logic [31:0] c_op2 [32];
    logic [31:0] exp15, exp31;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    drop_b = 1'b0; extra_b = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_op_valid", ov_a, 0);
    check_eq("rst_op1", o1_a, SEED1);
    check_eq("rst_op2", o2_a, SEED2);
    check_eq("rst_sig", sig_a, 0);
    check_eq("rst_busy_done", {busy_a, done_a, err_a}, 0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);

    // A: basic run
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
    check_eq("a_ov_c1", ov_a, 1);
    check_eq("a_op1_c1", o1_a, 32'h3F800000);
    check_eq("a_op2_c1", o2_a, 32'h40000000);
    @(negedge clk);
    cyc = 2;
    check_eq("a_op1_c2", o1_a, 32'h1FC00000);
    check_eq("a_op2_c2", o2_a, 32'h20000000);
    check_eq("a_busy", busy_a, 1);
    while (!done_a && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("a_done_cyc", cyc, 6);
    check_eq("a_vec_count", cnt_a, 4);
    check_eq("a_sig", sig_a, sig_model(4));
    check_eq("a_err", err_a, 0);
    check_eq("a_busy_done", busy_a, 0);

    // B: reset mid-RUN at cycle 4
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("b_busy_c4", busy_b, 1);
    rst_b = 1'b0;
    #1;
    check_eq("b_rst_ov", ov_b, 0);
    check_eq("b_rst_op1", o1_b, SEED1);
    check_eq("b_rst_op2", o2_b, SEED2);
    check_eq("b_rst_sig", sig_b, 0);
    check_eq("b_rst_cnt", cnt_b, 0);
    check_eq("b_rst_flags", {busy_b, done_b, err_b}, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    run_b(0, 0, cyc);
    check_eq("b_restart_ov", b_first_ov, 1);
    check_eq("b_restart_op1", b_first_op1, 32'h3F800000);
    check_eq("b_restart_op2", b_first_op2, 32'h40000000);
    check_eq("b_done_cyc", cyc, 12);
    check_eq("b_vec_count", cnt_b, 8);
    check_eq("b_sig", sig_b, sig_model(8));
    check_eq("b_err", err_b, 0);

    // B: start pulses during RUN (cycle 3) and DRAIN (cycle 10) are ignored
    run_b(3, 10, cyc);
    check_eq("b_ign_done_cyc", cyc, 12);
    check_eq("b_ign_sig", sig_b, sig_model(8));
    check_eq("b_ign_cnt", cnt_b, 8);
    check_eq("b_ign_err", err_b, 0);

    // B: second result_valid dropped
    drop_b = 1'b1;
    run_b(0, 0, cyc);
    drop_b = 1'b0;
    check_eq("b_drop_err", err_b, 1);
    check_eq("b_drop_cnt", cnt_b, 7);

    // B: clean run, then a spurious result_valid in DONE
    run_b(0, 0, cyc);
    check_eq("b_clean_err", err_b, 0);
    check_eq("b_clean_sig", sig_b, sig_model(8));
    extra_b = 1'b1;
    @(negedge clk);
    extra_b = 1'b0;
    @(negedge clk);
    check_eq("b_extra_err", err_b, 1);
    check_eq("b_extra_sig", sig_b, sig_model(8));
    check_eq("b_extra_cnt", cnt_b, 8);
    check_eq("b_extra_done", done_b, 1);

    // C: op2 at issues 15 and 31
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    cyc = 1;
    iss = 0;
    while (!done_c && cyc < 200) begin
      if (ov_c && iss < 32) begin
        c_op2[iss] = o2_c;
        iss++;
      end
      @(negedge clk);
      cyc++;
    end
`ifdef ONTEST_SPECIAL_EN
    exp15 = 32'h00000000;
    exp31 = 32'hFF800000;
`else
    exp15 = lfsr_n(SEED2, 15);
    exp31 = lfsr_n(SEED2, 31);
`endif
    check_eq("c_issues", iss, 32);
    check_eq("c_op2_i14", c_op2[14], lfsr_n(SEED2, 14));
    check_eq("c_op2_i15", c_op2[15], exp15);
    check_eq("c_op2_i16", c_op2[16], lfsr_n(SEED2, 16));
    check_eq("c_op2_i31", c_op2[31], exp31);
    check_eq("c_done_cyc", cyc, 34);
    check_eq("c_vec_count", cnt_c, 32);
    check_eq("c_err", err_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
